// File: rtl/alu_compare_seq.sv
// Multi-cycle magnitude comparator: walks the operands chunk by chunk from the MSB end,
// stops at the first differing chunk and reports the selected relation with a done pulse.
module alu_compare_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             result,
   output logic             isLT,
   output logic             isEqual
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_TOP = KW'(N - 1);

   localparam logic [2:0] MODE_EQ = 3'd0;
   localparam logic [2:0] MODE_NE = 3'd1;
   localparam logic [2:0] MODE_LT = 3'd2;
   localparam logic [2:0] MODE_GE = 3'd3;
   localparam logic [2:0] MODE_LE = 3'd4;
   localparam logic [2:0] MODE_GT = 3'd5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       mode_q, mode_d;
   logic [KW-1:0]    k_q, k_d;
   logic             result_q, result_d;
   logic             is_lt_q, is_lt_d;
   logic             is_equal_q, is_equal_d;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [WIDTH-1:0] sign_flip;

   function automatic logic relation(input logic [2:0] m, input logic lt, input logic eq);
      case (m)
         MODE_EQ: relation = eq;
         MODE_NE: relation = !eq;
         MODE_LT: relation = lt;
         MODE_GE: relation = !lt;
         MODE_LE: relation = lt | eq;
         MODE_GT: relation = !(lt | eq);
         default: relation = 1'b0;
      endcase
   endfunction

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign sign_flip = {signed_op, {(WIDTH-1){1'b0}}};
   assign a_chunk   = a_q[int'(k_q)*CHUNK +: CHUNK];
   assign b_chunk   = b_q[int'(k_q)*CHUNK +: CHUNK];

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      mode_d     = mode_q;
      k_d        = k_q;
      result_d   = result_q;
      is_lt_d    = is_lt_q;
      is_equal_d = is_equal_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_d     = A ^ sign_flip;
               b_d     = B ^ sign_flip;
               mode_d  = mode;
               k_d     = K_TOP;
               state_d = RUN;
            end
         end
         RUN: begin
            if (a_chunk != b_chunk) begin
               is_lt_d    = (a_chunk < b_chunk);
               is_equal_d = 1'b0;
               result_d   = relation(mode_q, a_chunk < b_chunk, 1'b0);
               state_d    = DONE;
            end else if (k_q == '0) begin
               is_lt_d    = 1'b0;
               is_equal_d = 1'b1;
               result_d   = relation(mode_q, 1'b0, 1'b1);
               state_d    = DONE;
            end else begin
               k_d = k_q - KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         mode_q     <= '0;
         k_q        <= '0;
         result_q   <= 1'b0;
         is_lt_q    <= 1'b0;
         is_equal_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mode_q     <= mode_d;
         k_q        <= k_d;
         result_q   <= result_d;
         is_lt_q    <= is_lt_d;
         is_equal_q <= is_equal_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign result  = result_q;
   assign isLT    = is_lt_q;
   assign isEqual = is_equal_q;

endmodule

// File: tb/tb_alu_compare_seq.sv
// Directed self-checking bench for alu_compare_seq with hand-computed expectations.
module tb_alu_compare_seq;

   logic        clock;
   logic        resetn;
   logic        start;
   logic [2:0]  mode;
   logic        signed_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        result;
   logic        isLT;
   logic        isEqual;

   int total = 0;
   int bad   = 0;
   int lat;
   int busy_cnt;
   int done_cnt;

   alu_compare_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clock(clock), .resetn(resetn), .start(start), .mode(mode), .signed_op(signed_op),
      .A(A), .B(B), .busy(busy), .done(done), .result(result), .isLT(isLT), .isEqual(isEqual)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request so it is sampled at the next rising edge; returns 1ns after that edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                         input logic sgn);
      @(negedge clock);
      A = a; B = b; mode = m; signed_op = sgn; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Counts cycles from the current one (numbered 1) until done is seen, bounded.
   task automatic wait_done(input string tag, output int l, output int bc);
      logic overlap;
      overlap = 1'b0;
      l  = 1;
      bc = 0;
      while (!done && l < 20) begin
         if (busy) bc++;
         @(posedge clock);
         #1;
         l++;
      end
      if (busy && done) overlap = 1'b1;
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      check({tag, "_busy_done_overlap"}, {31'd0, overlap}, 32'd0);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; mode = 3'd0; signed_op = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", {31'd0, result}, 32'd0);
      check("rst_isLT", {31'd0, isLT}, 32'd0);
      check("rst_isEqual", {31'd0, isEqual}, 32'd0);
      resetn = 1'b1;

      // -1 < 1 signed; top chunk differs so latency is 2
      launch(32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b1);
      wait_done("slt", lat, busy_cnt);
      check("slt_lat", lat, 32'd2);
      check("slt_result", {31'd0, result}, 32'd1);
      check("slt_isLT", {31'd0, isLT}, 32'd1);

      launch(32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0);
      wait_done("ult", lat, busy_cnt);
      check("ult_lat", lat, 32'd2);
      check("ult_result", {31'd0, result}, 32'd0);
      check("ult_isLT", {31'd0, isLT}, 32'd0);
      check("ult_isEqual", {31'd0, isEqual}, 32'd0);

      launch(32'h12345678, 32'h12345678, 3'd0, 1'b0);
      wait_done("eq", lat, busy_cnt);
      check("eq_lat", lat, 32'd5);
      check("eq_busy_cycles", busy_cnt, 32'd4);
      check("eq_result", {31'd0, result}, 32'd1);
      check("eq_isEqual", {31'd0, isEqual}, 32'd1);

      launch(32'h12345678, 32'h12345678, 3'd1, 1'b0);
      wait_done("ne", lat, busy_cnt);
      check("ne_result", {31'd0, result}, 32'd0);

      launch(32'h12345677, 32'h12345678, 3'd4, 1'b0);
      wait_done("le", lat, busy_cnt);
      check("le_lat", lat, 32'd5);
      check("le_result", {31'd0, result}, 32'd1);
      check("le_isLT", {31'd0, isLT}, 32'd1);

      launch(32'h80000000, 32'h7FFFFFFF, 3'd5, 1'b1);
      wait_done("sgt", lat, busy_cnt);
      check("sgt_result", {31'd0, result}, 32'd0);

      launch(32'h80000000, 32'h7FFFFFFF, 3'd5, 1'b0);
      wait_done("ugt", lat, busy_cnt);
      check("ugt_result", {31'd0, result}, 32'd1);

      // A start during RUN with different operands and mode must be ignored
      launch(32'h12345600, 32'h12345601, 3'd2, 1'b0);
      A = 32'h00000005; B = 32'h00000001; mode = 3'd0; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_done("ign", lat, busy_cnt);
      check("ign_lat", lat + 1, 32'd5);
      check("ign_result", {31'd0, result}, 32'd1);
      check("ign_isLT", {31'd0, isLT}, 32'd1);

      // Back-to-back: second request latched in the DONE cycle of the first
      launch(32'h01000000, 32'h02000000, 3'd2, 1'b0);
      wait_done("b2b1", lat, busy_cnt);
      check("b2b1_lat", lat, 32'd2);
      check("b2b1_result", {31'd0, result}, 32'd1);
      A = 32'h00000005; B = 32'h00000003; mode = 3'd2; signed_op = 1'b0; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
      wait_done("b2b2", lat, busy_cnt);
      check("b2b2_lat", lat, 32'd5);
      check("b2b2_result", {31'd0, result}, 32'd0);

      launch(32'h00000000, 32'h00000000, 3'd7, 1'b0);
      wait_done("rsv", lat, busy_cnt);
      check("rsv_result", {31'd0, result}, 32'd0);
      check("rsv_isEqual", {31'd0, isEqual}, 32'd1);

      launch(32'h00000003, 32'h00000003, 3'd4, 1'b0);
      wait_done("le_eq", lat, busy_cnt);
      check("le_eq_result", {31'd0, result}, 32'd1);

      // Reset in the second RUN cycle discards the operation
      launch(32'hAAAAAAAA, 32'hAAAAAAAA, 3'd0, 1'b0);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", {31'd0, result}, 32'd0);
      resetn = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (done) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 32'd0);

      launch(32'h00000010, 32'h00000020, 3'd2, 1'b0);
      wait_done("fresh", lat, busy_cnt);
      check("fresh_lat", lat, 32'd5);
      check("fresh_result", {31'd0, result}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
